// File: rtl/adpll_freq_monitor_if.sv
// Bundles the frequency-monitor signals: REF sample, multiplier, lock in; measurement results out.
// No added latency; wires only.
// No backpressure: every signal is a plain level or a single-cycle pulse.
interface adpll_freq_monitor_if #(
    parameter int CW = 8
);
    logic          ref_clk;
    logic [2:0]    m;
    logic          lock;
    logic [CW-1:0] meas;
    logic          meas_vld;
    logic          freq_ok;
    logic          freq_err;
    logic [7:0]    err_cnt;

    // master drives the ADPLL-side observations and reads the results
    modport master (
        output ref_clk, m, lock,
        input  meas, meas_vld, freq_ok, freq_err, err_cnt
    );

    // slave is the monitor itself
    modport slave (
        input  ref_clk, m, lock,
        output meas, meas_vld, freq_ok, freq_err, err_cnt
    );
endinterface

// File: rtl/adpll_freq_monitor.sv
// Counts OUT_CLK cycles per REF_CLK period, checks against (M+1)*MULT_UNIT; FREQ_MON_STICKY_ERR_EN makes FREQ_ERR sticky.
// MEAS_VLD arrives 1 cycle after the synchronised REF rise (3-4 OUT_CLK after the REF edge).
// No backpressure: results are single-cycle pulses with held levels; a consumer must sample on MEAS_VLD.
module adpll_freq_monitor #(
    parameter int CW        = 8,
    parameter int MULT_UNIT = 4,
    parameter int TOL       = 1,
    parameter int GOOD_N    = 4
) (
    input  logic                  i_out_clk,
    input  logic                  i_rst_n,
    adpll_freq_monitor_if.slave   io_mon
);
    localparam int              GW      = $clog2(GOOD_N + 1);
    localparam logic [CW-1:0]   CNT_MAX = '1;
    localparam logic [CW-1:0]   TOL_W   = CW'(TOL);
    localparam logic [GW-1:0]   GOOD_W  = GW'(GOOD_N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_ref1, r_ref2, r_ref3;
    logic           r_lock1, r_lock2;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_m_q;
    logic [CW-1:0]  r_meas;
    logic           r_meas_vld;
    logic           r_freq_ok;
    logic           r_freq_err;
    logic [7:0]     r_err_cnt;
    logic [GW-1:0]  r_good_cnt;

    logic           w_rise;
    logic           w_mchg;
    logic           w_timeout;
    logic           w_take;
    logic           w_clear;
    logic           w_good;
    logic [CW-1:0]  w_exp;
    logic [CW-1:0]  w_diff;

    assign w_rise    = r_ref2 & ~r_ref3;
    assign w_mchg    = (r_m_q != io_mon.m);
    assign w_timeout = (r_cnt == CNT_MAX);

    // Expected count and tolerance test on the count about to be latched as MEAS
    always_comb begin
        w_exp  = CW'((int'(r_m_q) + 1) * MULT_UNIT);
        w_diff = (r_cnt >= w_exp) ? (r_cnt - w_exp) : (w_exp - r_cnt);
        w_good = !w_timeout && (w_diff <= TOL_W);
    end

    // Two-flop synchronisers for REF and LOCK, extra REF stage for edge detect, M history
    always_ff @(posedge i_out_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ref1  <= 1'b0;
            r_ref2  <= 1'b0;
            r_ref3  <= 1'b0;
            r_lock1 <= 1'b0;
            r_lock2 <= 1'b0;
            r_m_q   <= 3'd0;
        end else begin
            r_ref1  <= io_mon.ref_clk;
            r_ref2  <= r_ref1;
            r_ref3  <= r_ref2;
            r_lock1 <= io_mon.lock;
            r_lock2 <= r_lock1;
            r_m_q   <= io_mon.m;
        end
    end

    // Period counter: restarts at 1 on every REF rise, saturates at all-ones
    always_ff @(posedge i_out_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= CW'(1);
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // State register
    always_ff @(posedge i_out_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; priority is lock loss, then M change, then timeout, then REF rise
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_clear     = 1'b0;
        if (!r_lock2) begin
            w_state_nxt = IDLE;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = ARM;
                ARM: begin
                    if (w_mchg) begin
                        w_clear = 1'b1;
                    end else if (w_rise) begin
                        w_state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (w_mchg) begin
                        w_state_nxt = ARM;
                        w_clear     = 1'b1;
                    end else if (w_timeout) begin
                        w_state_nxt = ARM;
                        w_take      = 1'b1;
                    end else if (w_rise) begin
                        w_take      = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Latch a measurement and update the good-run / error bookkeeping
    always_ff @(posedge i_out_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meas     <= '0;
            r_meas_vld <= 1'b0;
            r_freq_ok  <= 1'b0;
            r_freq_err <= 1'b0;
            r_err_cnt  <= 8'd0;
            r_good_cnt <= '0;
        end else begin
            r_meas_vld <= w_take;
            if (w_take) begin
                r_meas <= r_cnt;
            end
`ifdef FREQ_MON_STICKY_ERR_EN
            if (w_take && !w_good) begin
                r_freq_err <= 1'b1;
            end
`else
            r_freq_err <= w_take && !w_good;
`endif
            if (w_clear) begin
                r_good_cnt <= '0;
                r_freq_ok  <= 1'b0;
            end else if (w_take) begin
                if (w_good) begin
                    if (r_good_cnt != GOOD_W) begin
                        r_good_cnt <= r_good_cnt + GW'(1);
                    end
                    if (r_good_cnt >= GOOD_W - GW'(1)) begin
                        r_freq_ok <= 1'b1;
                    end
                end else begin
                    r_good_cnt <= '0;
                    r_freq_ok  <= 1'b0;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign io_mon.meas     = r_meas;
    assign io_mon.meas_vld = r_meas_vld;
    assign io_mon.freq_ok  = r_freq_ok;
    assign io_mon.freq_err = r_freq_err;
    assign io_mon.err_cnt  = r_err_cnt;
endmodule

// File: tb/tb_adpll_freq_monitor.sv
// Randomised REF periods against a period-level reference model; scoreboard checks every MEAS_VLD.
// Stimulus is driven 1 time unit after the OUT_CLK rising edge, results sampled on the falling edge.
// The DUT has no backpressure; the monitor simply consumes each MEAS_VLD pulse.
module tb_adpll_freq_monitor;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    adpll_freq_monitor_if #(.CW(8)) mon();

    adpll_freq_monitor #(
        .CW(8), .MULT_UNIT(4), .TOL(1), .GOOD_N(4)
    ) dut (
        .i_out_clk (clk),
        .i_rst_n   (rst_n),
        .io_mon    (mon)
    );

    always #5 clk = ~clk;

    typedef struct {
        int meas;
        int ok;
        int err;
        int ecnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state, expressed per REF period
    int   active = 0;     // next REF rise closes a period that is measured
    int   gc     = 0;     // consecutive good periods
    int   ecnt   = 0;     // bad periods seen
    int   sticky = 0;
    int   cur_m  = 3;
    int   prev_p = 0;
    int   prev_m = 3;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One finished period of p OUT_CLK cycles at multiplier m (p >= 255 means timeout)
    task automatic model_period(input int p, input int m);
        exp_t e;
        int   expc, dif, bad;
        expc = (m + 1) * 4;
        dif  = (p > expc) ? p - expc : expc - p;
        bad  = (p >= 255) || (dif > 1);
        e.meas = (p >= 255) ? 255 : p;
        if (bad) begin
            gc     = 0;
            ecnt   = (ecnt < 255) ? ecnt + 1 : 255;
            sticky = 1;
        end else begin
            gc = (gc < 4) ? gc + 1 : 4;
        end
        e.ok   = (gc == 4) ? 1 : 0;
        e.ecnt = ecnt;
`ifdef FREQ_MON_STICKY_ERR_EN
        e.err  = sticky;
`else
        e.err  = bad;
`endif
        q.push_back(e);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_meas"},     int'(mon.meas), 0);
        chk({tag, "_meas_vld"}, int'(mon.meas_vld), 0);
        chk({tag, "_freq_ok"},  int'(mon.freq_ok), 0);
        chk({tag, "_freq_err"}, int'(mon.freq_err), 0);
        chk({tag, "_err_cnt"},  int'(mon.err_cnt), 0);
    endtask

    // One REF period starting with a rising edge. action: 1 = change M, 2 = LOCK blip,
    // 3 = async reset pulse; actions happen mid low-phase and need p >= 40.
    task automatic ref_period(input int p, input int action, input int new_m);
        int hi, rest;
        if (active != 0) model_period(prev_p, prev_m);
        active = 1;
        if (p >= 255) begin
            model_period(p, cur_m);
            active = 0;
        end
        prev_p = p;
        prev_m = cur_m;
        hi   = p / 2;
        rest = p - hi;
        mon.ref_clk = 1'b1;
        tick(hi);
        mon.ref_clk = 1'b0;
        if (action != 0) begin
            tick(2);
            rest -= 2;
            case (action)
                1: begin
                    chk("freq_ok_before_mchg", int'(mon.freq_ok), (gc == 4) ? 1 : 0);
                    mon.m  = 3'(new_m);
                    cur_m  = new_m;
                    active = 0;
                    gc     = 0;
                    tick(2);
                    rest -= 2;
                    chk("freq_ok_after_mchg", int'(mon.freq_ok), 0);
                end
                2: begin
                    chk("freq_ok_before_lockdrop", int'(mon.freq_ok), (gc == 4) ? 1 : 0);
                    mon.lock = 1'b0;
                    active   = 0;
                    gc       = 0;
                    tick(4);
                    chk("freq_ok_after_lockdrop", int'(mon.freq_ok), 0);
                    chk("err_cnt_hold_lockdrop", int'(mon.err_cnt), ecnt);
                    tick(2);
                    rest -= 6;
                    mon.lock = 1'b1;
                end
                default: begin
                    chk("queue_empty_before_reset", q.size(), 0);
                    #2;
                    rst_n = 1'b0;
                    #1;
                    chk_outputs_zero("async_reset");
                    q.delete();
                    active = 0;
                    gc     = 0;
                    ecnt   = 0;
                    sticky = 0;
                    tick(2);
                    rest -= 2;
                    rst_n = 1'b1;
                end
            endcase
        end
        tick(rest);
    endtask

    // Scoreboard monitor: every MEAS_VLD must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mon.meas_vld) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_meas_vld meas=%0d expected=none at %0t", mon.meas, $time);
            end else begin
                e = q.pop_front();
                chk("meas",     int'(mon.meas), e.meas);
                chk("freq_ok",  int'(mon.freq_ok), e.ok);
                chk("freq_err", int'(mon.freq_err), e.err);
                chk("err_cnt",  int'(mon.err_cnt), e.ecnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int p, nm, r, e;
        mon.ref_clk = 1'b0;
        mon.m       = 3'd3;
        mon.lock    = 1'b0;
        tick(5);
        chk_outputs_zero("reset");
        rst_n    = 1'b1;
        mon.lock = 1'b1;
        tick(10);

        // 16x at M=3: first rise discarded, FREQ_OK after the 4th good period
        for (int i = 0; i < 6; i++) ref_period(16, 0, 0);
        // over-frequency then in-tolerance under-frequency
        for (int i = 0; i < 2; i++) ref_period(18, 0, 0);
        for (int i = 0; i < 5; i++) ref_period(15, 0, 0);
        for (int i = 0; i < 5; i++) ref_period(16, 0, 0);
        // M 3 -> 1 mid-period, then 8x
        ref_period(40, 1, 1);
        for (int i = 0; i < 6; i++) ref_period(8, 0, 0);

        // randomised periods, M changes and lock blips
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do nm = $urandom_range(0, 6); while (nm == cur_m);
                ref_period(40, 1, nm);
            end else if (r == 1) begin
                ref_period(40, 2, 0);
            end else begin
                e = (cur_m + 1) * 4;
                case ($urandom_range(0, 3))
                    0:       p = e;
                    1:       p = e - 1 + 2 * $urandom_range(0, 1);
                    2:       p = e - 2 + 4 * $urandom_range(0, 1);
                    default: p = $urandom_range(6, 70);
                endcase
                if (p < 6) p = 6;
                ref_period(p, 0, 0);
            end
        end

        // M=7 (32x): longest non-timeout period, then a stopped REF
        ref_period(40, 1, 7);
        for (int i = 0; i < 4; i++) ref_period(32, 0, 0);
        ref_period(254, 0, 0);
        for (int i = 0; i < 2; i++) ref_period(32, 0, 0);
        ref_period(300, 0, 0);
        for (int i = 0; i < 5; i++) ref_period(32, 0, 0);

        // lock drop mid-period, then async reset mid-period
        ref_period(40, 2, 0);
        for (int i = 0; i < 6; i++) ref_period(32, 0, 0);
        ref_period(40, 3, 0);
        for (int i = 0; i < 6; i++) ref_period(32, 0, 0);

        // error counter saturation: 300 bad periods at M=3
        ref_period(40, 1, 3);
        for (int i = 0; i < 300; i++) ref_period(6, 0, 0);
        ref_period(16, 0, 0);
        tick(20);
        chk("err_cnt_saturated", int'(mon.err_cnt), 255);
        chk("scoreboard_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
